// File: rtl/mc6845_pixel_serializer_if.sv
// ---------------------------------------------------------------------------
// mc6845_pixel_serializer_if
// Bundles every signal between the pixel serializer, the MC6845 CRTC, the
// character VRAM, the font ROM and the video output.
//   CHAR_CLK           character clock back to the CRTC
//   MA, RA             CRTC memory / raster row address
//   DE, HSYNC, VSYNC   CRTC timing outputs
//   CURSOR             CRTC cursor flag for the current character
//   VRAM_ADDR/DATA     character RAM port (data 1 CLK after address)
//   FONT_ADDR/DATA     font ROM port (data 1 CLK after address)
//   PIXEL              serial pixel stream
//   HSYNC_O/VSYNC_O/DE_O  timing delayed to line up with PIXEL
// Modports: master = serializer side, slave = CRTC/memory/display side.
// ---------------------------------------------------------------------------
interface mc6845_pixel_serializer_if #(
  parameter int CHAR_WIDTH = 8,
  parameter int ROW_BITS   = 4
);
  logic                    CHAR_CLK;
  logic [13:0]             MA;
  logic [4:0]              RA;
  logic                    DE;
  logic                    HSYNC;
  logic                    VSYNC;
  logic                    CURSOR;
  logic [13:0]             VRAM_ADDR;
  logic [7:0]              VRAM_DATA;
  logic [7+ROW_BITS:0]     FONT_ADDR;
  logic [CHAR_WIDTH-1:0]   FONT_DATA;
  logic                    PIXEL;
  logic                    HSYNC_O;
  logic                    VSYNC_O;
  logic                    DE_O;

  modport master (
    output CHAR_CLK, VRAM_ADDR, FONT_ADDR, PIXEL, HSYNC_O, VSYNC_O, DE_O,
    input  MA, RA, DE, HSYNC, VSYNC, CURSOR, VRAM_DATA, FONT_DATA
  );

  modport slave (
    input  CHAR_CLK, VRAM_ADDR, FONT_ADDR, PIXEL, HSYNC_O, VSYNC_O, DE_O,
    output MA, RA, DE, HSYNC, VSYNC, CURSOR, VRAM_DATA, FONT_DATA
  );
endinterface

// File: rtl/mc6845_pixel_serializer.sv
// ---------------------------------------------------------------------------
// mc6845_pixel_serializer
// Dot-clock video back end for an MC6845 CRTC. Divides the dot clock into
// the character clock, samples the CRTC once per character, fetches the
// character code from VRAM and its row bitmap from the font ROM, and shifts
// the bitmap out MSB first. HSYNC/VSYNC/DE are delayed through the same
// pipeline so they stay aligned with the pixels; cursor characters are
// inverted. First pixel of a character appears CHAR_WIDTH CLKs after the
// edge that sampled it.
// Ports:
//   CLK   dot clock, rising edge
//   RST   synchronous active-high reset
//   bus   mc6845_pixel_serializer_if.master (CRTC, VRAM, font, video out)
// Build option:
//   CURSOR_BLINK_EN  when defined, a 5-bit frame counter (counting VSYNC
//                    rising edges) blinks the cursor: 16 frames on, 16 off.
//                    Undefined: steady cursor, no frame counter.
// ---------------------------------------------------------------------------
module mc6845_pixel_serializer #(
  parameter int CHAR_WIDTH = 8,
  parameter int ROW_BITS   = 4
) (
  input logic                      CLK,
  input logic                      RST,
  mc6845_pixel_serializer_if.master bus
);

  localparam int DW = $clog2(CHAR_WIDTH);
  localparam logic [DW-1:0] LAST_DOT = DW'(CHAR_WIDTH - 1);
  localparam logic [DW-1:0] HALF_DOT = DW'(CHAR_WIDTH / 2);

  logic [DW-1:0]           r_dotCnt;
  logic [DW-1:0]           w_dotNext;
  logic                    r_charClk;

  logic [ROW_BITS-1:0]     r_raS;
  logic                    r_deS;
  logic                    r_hsyncS;
  logic                    r_vsyncS;
  logic                    r_cursorS;

  logic [13:0]             r_vramAddr;
  logic [7+ROW_BITS:0]     r_fontAddr;
  logic [CHAR_WIDTH-1:0]   r_hold;
  logic [CHAR_WIDTH-1:0]   r_shift;
  logic                    r_pixel;

  // Timing captured at the load edge, then released one CLK later together
  // with the first pixel of the same character.
  logic                    r_deL;
  logic                    r_hsyncL;
  logic                    r_vsyncL;
  logic                    r_deO;
  logic                    r_hsyncO;
  logic                    r_vsyncO;

  logic                    w_blinkOn;
  logic                    w_curVis;

  // Next dot position, wrapping at the end of the character.
  always_comb begin
    w_dotNext = (r_dotCnt == LAST_DOT) ? '0 : r_dotCnt + 1'b1;
  end

`ifdef CURSOR_BLINK_EN
  logic [4:0] r_frameCnt;

  // Frame counter advances when the sampled VSYNC goes from 0 to 1 between
  // two consecutive character samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frameCnt <= '0;
    end else if (r_dotCnt == '0 && bus.VSYNC && !r_vsyncS) begin
      r_frameCnt <= r_frameCnt + 5'd1;
    end
  end

  assign w_blinkOn = ~r_frameCnt[4];
`else
  assign w_blinkOn = 1'b1;
`endif

  assign w_curVis = r_cursorS & r_deS & w_blinkOn;

  // Character sequencer: dot counter, character clock, CRTC sampling,
  // VRAM/font fetch, shift register and delayed timing outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dotCnt   <= '0;
      r_charClk  <= 1'b1;
      r_raS      <= '0;
      r_deS      <= 1'b0;
      r_hsyncS   <= 1'b0;
      r_vsyncS   <= 1'b0;
      r_cursorS  <= 1'b0;
      r_vramAddr <= '0;
      r_fontAddr <= '0;
      r_hold     <= '0;
      r_shift    <= '0;
      r_pixel    <= 1'b0;
      r_deL      <= 1'b0;
      r_hsyncL   <= 1'b0;
      r_vsyncL   <= 1'b0;
      r_deO      <= 1'b0;
      r_hsyncO   <= 1'b0;
      r_vsyncO   <= 1'b0;
    end else begin
      r_dotCnt  <= w_dotNext;
      // Registered from the next count so CHAR_CLK tracks dot_cnt exactly;
      // the CRTC then advances mid-character and MA/RA are stable at dot 0.
      r_charClk <= (w_dotNext < HALF_DOT);

      r_pixel  <= r_shift[CHAR_WIDTH-1];
      r_deO    <= r_deL;
      r_hsyncO <= r_hsyncL;
      r_vsyncO <= r_vsyncL;

      if (r_dotCnt == '0) begin
        r_raS      <= bus.RA[ROW_BITS-1:0];
        r_deS      <= bus.DE;
        r_hsyncS   <= bus.HSYNC;
        r_vsyncS   <= bus.VSYNC;
        r_cursorS  <= bus.CURSOR;
        r_vramAddr <= bus.MA;
      end

      if (r_dotCnt == DW'(2)) begin
        r_fontAddr <= {bus.VRAM_DATA, r_raS};
      end

      if (r_dotCnt == DW'(4)) begin
        r_hold <= bus.FONT_DATA;
      end

      if (r_dotCnt == LAST_DOT) begin
        r_shift  <= r_deS ? (r_hold ^ {CHAR_WIDTH{w_curVis}}) : '0;
        r_deL    <= r_deS;
        r_hsyncL <= r_hsyncS;
        r_vsyncL <= r_vsyncS;
      end else begin
        r_shift <= {r_shift[CHAR_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign bus.CHAR_CLK  = r_charClk;
  assign bus.VRAM_ADDR = r_vramAddr;
  assign bus.FONT_ADDR = r_fontAddr;
  assign bus.PIXEL     = r_pixel;
  assign bus.HSYNC_O   = r_hsyncO;
  assign bus.VSYNC_O   = r_vsyncO;
  assign bus.DE_O      = r_deO;

endmodule

// File: tb/tb_mc6845_pixel_serializer.sv
// ---------------------------------------------------------------------------
// tb_mc6845_pixel_serializer
// Directed bench for mc6845_pixel_serializer (CHAR_WIDTH=8, ROW_BITS=4).
// Each character is driven for 8 dots; its expected pixels, timing and
// addresses are pushed into queues and a monitor compares the DUT output
// stream against them. Blink expectations follow CURSOR_BLINK_EN.
// ---------------------------------------------------------------------------
module tb_mc6845_pixel_serializer;

  localparam int CW = 8;
  localparam int RB = 4;

  typedef struct packed {
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        de;
    logic        hs;
    logic        vs;
    logic        cur;
    logic [7:0]  pix;
    logic [11:0] faddr;
  } vec_t;

  logic clk;
  logic rst;
  logic released;

  logic [7:0]  vram [0:16383];
  logic [7:0]  font [0:4095];
  logic [7:0]  vramData;
  logic [7:0]  fontData;

  vec_t pixQ[$];
  vec_t addrQ[$];

  int total;
  int bad;
  int nPushed;
  int charsDone;

  mc6845_pixel_serializer_if #(.CHAR_WIDTH(CW), .ROW_BITS(RB)) vif ();

  mc6845_pixel_serializer #(.CHAR_WIDTH(CW), .ROW_BITS(RB)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (vif)
  );

  // Dot clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous VRAM and font ROM: data one CLK after address
  always @(posedge clk) begin
    vramData <= vram[vif.VRAM_ADDR];
    fontData <= font[vif.FONT_ADDR];
  end
  assign vif.VRAM_DATA = vramData;
  assign vif.FONT_DATA = fontData;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one character for a full 8-dot period and queue its expectation
  task automatic applyStimulus(input vec_t v);
    vif.MA     = v.ma;
    vif.RA     = v.ra;
    vif.DE     = v.de;
    vif.HSYNC  = v.hs;
    vif.VSYNC  = v.vs;
    vif.CURSOR = v.cur;
    pixQ.push_back(v);
    addrQ.push_back(v);
    nPushed++;
    repeat (CW) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [13:0] ma, input logic [4:0] ra,
                              input logic de, input logic hs, input logic vs,
                              input logic cur, input logic [7:0] pix,
                              input logic [11:0] faddr);
    vec_t v;
    v.ma = ma; v.ra = ra; v.de = de; v.hs = hs; v.vs = vs; v.cur = cur;
    v.pix = pix; v.faddr = faddr;
    return v;
  endfunction

  // Monitor: counts edges after reset release and checks the character
  // clock every dot, addresses mid-character and the pixel stream.
  initial begin
    int e;
    int i;
    logic active;
    vec_t cur;
    vec_t a;
    e = 0;
    active = 1'b0;
    cur = '0;
    wait (released);
    forever begin
      @(posedge clk);
      e++;
      @(negedge clk);
      checkOutput("char_clk", 32'(vif.CHAR_CLK), 32'((e % CW) < (CW / 2)));
      if (e >= 5 && ((e - 5) % CW) == 0 && addrQ.size() > 0) begin
        a = addrQ.pop_front();
        checkOutput("vram_addr", 32'(vif.VRAM_ADDR), 32'(a.ma));
        checkOutput("font_addr", 32'(vif.FONT_ADDR), 32'(a.faddr));
      end
      if (e >= CW + 1) begin
        i = (e - CW - 1) % CW;
        if (i == 0) begin
          if (pixQ.size() > 0) begin
            cur = pixQ.pop_front();
            active = 1'b1;
          end else begin
            active = 1'b0;
          end
        end
        if (active) begin
          checkOutput("pixel",   32'(vif.PIXEL),   32'(cur.pix[7-i]));
          checkOutput("de_o",    32'(vif.DE_O),    32'(cur.de));
          checkOutput("hsync_o", 32'(vif.HSYNC_O), 32'(cur.hs));
          checkOutput("vsync_o", 32'(vif.VSYNC_O), 32'(cur.vs));
          if (i == CW - 1) charsDone++;
        end
      end
    end
  end

  // Main stimulus
  initial begin
    logic [7:0] blinkPix;
    total = 0;
    bad = 0;
    nPushed = 0;
    charsDone = 0;
    released = 1'b0;
    for (int k = 0; k < 16384; k++) vram[k] = 8'h00;
    for (int k = 0; k < 4096; k++) font[k] = 8'h00;
    vram[14'h0123] = 8'h41;
    vram[14'h0200] = 8'h5A;
    vram[14'h3FFF] = 8'h7E;
    font[12'h412]  = 8'h3C;
    font[12'h413]  = 8'hF0;
    font[12'h5A7]  = 8'hA5;
    font[12'h7EF]  = 8'h81;

    rst = 1'b1;
    vif.MA = 14'h1555; vif.RA = 5'h15; vif.DE = 1'b1;
    vif.HSYNC = 1'b1; vif.VSYNC = 1'b1; vif.CURSOR = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_char_clk", 32'(vif.CHAR_CLK),  32'd1);
    checkOutput("rst_vram_addr", 32'(vif.VRAM_ADDR), 32'd0);
    checkOutput("rst_font_addr", 32'(vif.FONT_ADDR), 32'd0);
    checkOutput("rst_pixel",    32'(vif.PIXEL),     32'd0);
    checkOutput("rst_hsync_o",  32'(vif.HSYNC_O),   32'd0);
    checkOutput("rst_vsync_o",  32'(vif.VSYNC_O),   32'd0);
    checkOutput("rst_de_o",     32'(vif.DE_O),      32'd0);
    rst = 1'b0;
    released = 1'b1;

    //                ma       ra     de    hs    vs    cur   pix    faddr
    applyStimulus(mk(14'h0123, 5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 12'h412));
    applyStimulus(mk(14'h0123, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h412));
    applyStimulus(mk(14'h0123, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 12'h412));
    applyStimulus(mk(14'h0200, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 12'h5A7));
    applyStimulus(mk(14'h3FFF, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 12'h7EF));
    applyStimulus(mk(14'h0123, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'h412));
    applyStimulus(mk(14'h0123, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 12'h413));

    // Sixteen VSYNC pulses (blanked), then a cursor character
    for (int p = 0; p < 16; p++) begin
      applyStimulus(mk(14'h0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'h000));
      applyStimulus(mk(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000));
    end
`ifdef CURSOR_BLINK_EN
    blinkPix = 8'h3C;
`else
    blinkPix = 8'hC3;
`endif
    applyStimulus(mk(14'h0123, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, blinkPix, 12'h412));
    applyStimulus(mk(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000));

    vif.DE = 1'b0; vif.HSYNC = 1'b0; vif.VSYNC = 1'b0; vif.CURSOR = 1'b0;
    for (int t = 0; t < 64 && charsDone < nPushed; t++) @(posedge clk);
    @(negedge clk);
    if (charsDone < nPushed) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout actual=%0d expected=%0d", charsDone, nPushed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
